// File: rtl/ll_pkg.sv
// Shared types and constants for the lunar-lander sequencer.
package ll_pkg;

  typedef logic [2:0] ll_state_t;

  localparam ll_state_t StIdle    = 3'd0;
  localparam ll_state_t StFly     = 3'd1;
  localparam ll_state_t StLanded  = 3'd2;
  localparam ll_state_t StCrashed = 3'd3;
  localparam ll_state_t StPause   = 3'd4;

  localparam logic [4:0] KEY_PAUSE = 5'd10;
  localparam logic [4:0] KEY_W     = 5'd16;
  localparam logic [4:0] KEY_X     = 5'd17;
  localparam logic [4:0] KEY_Y     = 5'd18;
  localparam logic [4:0] KEY_Z     = 5'd19;

  localparam logic [15:0] BCD_NEG_TH = 16'h5000;

  // Ten's-complement BCD: the upper half of the range is negative.
  function automatic logic bcd_neg(logic [15:0] v);
    return v >= BCD_NEG_TH;
  endfunction

endpackage

// File: rtl/bcdaddsub4.sv
// Four-digit BCD adder/subtractor; op=0 adds, op=1 subtracts (ten's complement).
module bcdaddsub4 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        op,
  output logic [15:0] s
);

  logic       c;
  logic [3:0] bd;
  logic [4:0] t;

  always_comb begin
    c  = op;
    bd = '0;
    t  = '0;
    s  = '0;
    for (int i = 0; i < 4; i++) begin
      bd = op ? (4'd9 - b[4*i +: 4]) : b[4*i +: 4];
      t  = {1'b0, a[4*i +: 4]} + {1'b0, bd} + {4'b0000, c};
      if (t > 5'd9) begin
        s[4*i +: 4] = 4'(t - 5'd10);
        c           = 1'b1;
      end else begin
        s[4*i +: 4] = t[3:0];
        c           = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ll_sequencer.sv
// Game-flow FSM, physics tick divider and keypad decode for the lunar lander.
// Optional pause state is built in when LL_PAUSE_EN is defined.
module ll_sequencer
  import ll_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 25,
  parameter logic [15:0] THRUST_INIT = 16'h0005,
  parameter logic [15:0] CRASH_VEL   = 16'h9970
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keyclk,
  input  logic [4:0]  keyout,
  input  logic [15:0] alt,
  input  logic [15:0] vel,
  input  logic [15:0] fuel,
  input  logic [15:0] thrust,
  output logic        wen,
  output logic [15:0] thrust_n,
  output logic [1:0]  disp_sel,
  output logic [15:0] disp_val,
  output logic        flying,
  output logic        land,
  output logic        crash
);

  ll_state_t   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] thrust_q, thrust_d;
  logic [1:0]  sel_q, sel_d;
  logic        keyclk_q;

  logic        key_evt, is_digit, is_disp, pause_key, tick;
  logic        touchdown, crash_cond;
  logic [15:0] sum;

  assign key_evt  = keyclk & ~keyclk_q;
  assign is_digit = keyout <= 5'd9;
  assign is_disp  = (keyout >= KEY_W) && (keyout <= KEY_Z);
  assign tick     = (cnt_q == 8'(TICK_DIV - 1));

`ifdef LL_PAUSE_EN
  assign pause_key = key_evt & (keyout == KEY_PAUSE);
`else
  assign pause_key = 1'b0;
`endif

  bcdaddsub4 u_sum (
    .a  (alt),
    .b  (vel),
    .op (1'b0),
    .s  (sum)
  );

  assign touchdown  = (sum == 16'h0000) || bcd_neg(sum);
  assign crash_cond = bcd_neg(vel) && (vel < CRASH_VEL);

  // Pause pressed on a tick cycle suppresses the commit.
  assign wen = (state_q == StFly) & tick & ~pause_key;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    thrust_d = thrust_q;
    sel_d    = sel_q;
    if (key_evt && is_disp) begin
      sel_d = 2'(KEY_Z - keyout);
    end
    case (state_q)
      StIdle: begin
        if (key_evt && is_digit) begin
          thrust_d = {12'h000, keyout[3:0]};
          state_d  = StFly;
          cnt_d    = '0;
        end
      end
      StFly: begin
        if (key_evt && is_digit) begin
          thrust_d = {12'h000, keyout[3:0]};
        end
        if (pause_key) begin
          state_d = StPause;
        end else if (tick) begin
          cnt_d = '0;
          if (touchdown) begin
            state_d = crash_cond ? StCrashed : StLanded;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef LL_PAUSE_EN
      StPause: begin
        if (key_evt && is_digit) begin
          thrust_d = {12'h000, keyout[3:0]};
        end
        if (pause_key) begin
          state_d = StFly;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      thrust_q <= THRUST_INIT;
      sel_q    <= '0;
      keyclk_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      thrust_q <= thrust_d;
      sel_q    <= sel_d;
      keyclk_q <= keyclk;
    end
  end

  assign thrust_n = thrust_q;
  assign disp_sel = sel_q;
  assign flying   = (state_q == StFly);
  assign land     = (state_q == StLanded);
  assign crash    = (state_q == StCrashed);

  always_comb begin
    case (sel_q)
      2'd0:    disp_val = alt;
      2'd1:    disp_val = vel;
      2'd2:    disp_val = fuel;
      default: disp_val = thrust;
    endcase
  end

endmodule

// File: tb/tb_ll_sequencer.sv
// Randomized and directed bench for ll_sequencer against a behavioural model.
module tb_ll_sequencer;

  localparam int TD        = 4;
  localparam int CRASH_INT = 9970;
  localparam int MIdle = 0, MFly = 1, MLand = 2, MCrash = 3, MPause = 4;
`ifdef LL_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        keyclk;
  logic [4:0]  keyout;
  logic [15:0] alt, vel, fuel, thrust;
  logic        wen, flying, land, crash;
  logic [15:0] thrust_n, disp_val;
  logic [1:0]  disp_sel;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  ll_sequencer #(
    .TICK_DIV    (TD),
    .THRUST_INIT (16'h0005),
    .CRASH_VEL   (16'h9970)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .keyclk   (keyclk),
    .keyout   (keyout),
    .alt      (alt),
    .vel      (vel),
    .fuel     (fuel),
    .thrust   (thrust),
    .wen      (wen),
    .thrust_n (thrust_n),
    .disp_sel (disp_sel),
    .disp_val (disp_val),
    .flying   (flying),
    .land     (land),
    .crash    (crash)
  );

  always #5 clk = ~clk;

  function automatic int bcd2int(logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(int n);
    logic [15:0] r;
    r[15:12] = 4'((n / 1000) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: game phase plus cycles elapsed in flight modulo TD.
  int          m_state, m_phase;
  logic [15:0] m_thrust;
  int          m_sel;
  logic        m_kq;

  logic        e_evt, e_tick, e_pause, e_wen, e_td, e_crash;
  int          e_sum, e_vel;
  logic [15:0] e_disp;

  always_comb begin
    e_evt   = keyclk & ~m_kq;
    e_tick  = (m_state == MFly) && (m_phase == TD - 1);
    e_pause = PAUSE_EN && e_evt && (keyout == 5'd10);
    e_wen   = e_tick && !e_pause;
    e_sum   = (bcd2int(alt) + bcd2int(vel)) % 10000;
    e_vel   = bcd2int(vel);
    e_td    = (e_sum == 0) || (e_sum >= 5000);
    e_crash = (e_vel >= 5000) && (e_vel < CRASH_INT);
    case (m_sel)
      0:       e_disp = alt;
      1:       e_disp = vel;
      2:       e_disp = fuel;
      default: e_disp = thrust;
    endcase
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state  <= MIdle;
      m_phase  <= 0;
      m_thrust <= 16'h0005;
      m_sel    <= 0;
      m_kq     <= 1'b0;
    end else begin
      m_kq <= keyclk;
      if (e_evt && keyout >= 5'd16 && keyout <= 5'd19) m_sel <= 19 - int'(keyout);
      if (e_evt && keyout <= 5'd9 &&
          (m_state == MIdle || m_state == MFly || m_state == MPause))
        m_thrust <= 16'(keyout);
      case (m_state)
        MIdle: if (e_evt && keyout <= 5'd9) begin
          m_state <= MFly;
          m_phase <= 0;
        end
        MFly: begin
          if (e_pause) m_state <= MPause;
          else begin
            m_phase <= (m_phase + 1) % TD;
            if (e_tick && e_td) m_state <= e_crash ? MCrash : MLand;
          end
        end
        MPause: if (e_pause) m_state <= MFly;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("wen", 16'(wen), 16'(e_wen));
      check("thrust_n", thrust_n, m_thrust);
      check("disp_sel", 16'(disp_sel), 16'(m_sel));
      check("disp_val", disp_val, e_disp);
      check("flying", 16'(flying), 16'(m_state == MFly));
      check("land", 16'(land), 16'(m_state == MLand));
      check("crash", 16'(crash), 16'(m_state == MCrash));
    end
  end

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    keyclk = 1'b0;
    tick1();
    rst = 1'b0;
  endtask

  task automatic press(logic [4:0] code, int hold);
    keyclk = 1'b1;
    keyout = code;
    repeat (hold) tick1();
    keyclk = 1'b0;
    tick1();
  endtask

  // Bounded wait for a commit strobe; returns in the cycle after it.
  task automatic wait_wen(string name);
    bit found = 1'b0;
    for (int i = 0; i < 3 * TD && !found; i++) begin
      @(negedge clk);
      if (wen) found = 1'b1;
      tick1();
    end
    check(name, 16'(found), 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; keyclk = 1'b0; keyout = '0;
    alt = 16'h1000; vel = 16'h0000; fuel = 16'h0800; thrust = 16'h0007;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_on = 1'b1;

    @(negedge clk);
    check("rst_thrust_n", thrust_n, 16'h0005);
    check("rst_disp_sel", 16'(disp_sel), 16'd0);
    check("rst_flying", 16'(flying), 16'd0);
    repeat (20) begin
      @(negedge clk);
      check("idle_no_wen", 16'(wen), 16'd0);
    end
    tick1();

    // Start with digit 7; commits on FLY cycles 4, 8, 12.
    keyclk = 1'b1; keyout = 5'd7;
    tick1();
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) check("start_thrust_n", thrust_n, 16'h0007);
      check("start_wen_cycle", 16'(wen), 16'((k % 4) == 0));
      tick1();
      if (k == 1) keyclk = 1'b0;
    end

    press(5'd18, 1);
    @(negedge clk);
    check("disp_y_sel", 16'(disp_sel), 16'd1);
    check("disp_y_val", disp_val, 16'h0000);
    tick1();
    press(5'd19, 5);

    // Soft landing.
    alt = 16'h0010; vel = 16'h9980;
    wait_wen("land_wen_seen");
    @(negedge clk);
    check("land_flag", 16'(land), 16'd1);
    check("land_crash", 16'(crash), 16'd0);
    repeat (10) begin
      @(negedge clk);
      check("land_no_wen", 16'(wen), 16'd0);
    end
    tick1();
    press(5'd18, 1);
    @(negedge clk);
    check("land_disp_val", disp_val, 16'h9980);
    tick1();
    press(5'd16, 1);
    @(negedge clk);
    check("land_disp_w", 16'(disp_sel), 16'd3);
    check("land_disp_thr", disp_val, 16'h0007);
    tick1();

    // Crash.
    do_reset();
    alt = 16'h1000; vel = 16'h0000;
    press(5'd2, 1);
    repeat (3) tick1();
    alt = 16'h0040; vel = 16'h9950;
    wait_wen("crash_wen_seen");
    @(negedge clk);
    check("crash_flag", 16'(crash), 16'd1);
    check("crash_land", 16'(land), 16'd0);
    tick1();
    press(5'd3, 1);
    @(negedge clk);
    check("crash_thrust_kept", thrust_n, 16'h0002);
    tick1();

`ifdef LL_PAUSE_EN
    do_reset();
    alt = 16'h2000; vel = 16'h0000;
    press(5'd5, 1);
    wait_wen("pause_first_wen");
    tick1();
    tick1();
    keyclk = 1'b1; keyout = 5'd10;
    tick1();
    keyclk = 1'b0;
    repeat (30) begin
      @(negedge clk);
      check("pause_no_wen", 16'(wen), 16'd0);
      check("pause_not_flying", 16'(flying), 16'd0);
      tick1();
    end
    keyclk = 1'b1; keyout = 5'd10;
    tick1();
    keyclk = 1'b0;
    @(negedge clk);
    check("resume_wen_1", 16'(wen), 16'd0);
    tick1();
    @(negedge clk);
    check("resume_wen_2", 16'(wen), 16'd1);
    tick1();
`endif

    // Randomized episodes against the model.
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          if (!keyclk) begin
            int r;
            r = int'($urandom_range(0, 9));
            keyclk = 1'b1;
            if (r < 5)      keyout = 5'($urandom_range(0, 9));
            else if (r < 8) keyout = 5'($urandom_range(16, 19));
            else            keyout = 5'($urandom_range(10, 15));
          end else begin
            keyclk = 1'b0;
          end
        end
        if ($urandom_range(0, 29) == 0) begin
          alt = int2bcd(int'($urandom_range(0, 60)));
          vel = int2bcd(int'($urandom_range(9900, 9999)));
        end else begin
          alt = int2bcd(int'($urandom_range(1000, 4999)));
          vel = $urandom_range(0, 1) ? int2bcd(int'($urandom_range(0, 200)))
                                     : int2bcd(int'($urandom_range(9800, 9999)));
        end
        fuel   = int2bcd(int'($urandom_range(0, 9999)));
        thrust = int2bcd(int'($urandom_range(0, 9)));
        tick1();
      end
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ll_sequencer.md
# ll_sequencer

Flight-sequencing controller for the lunar-lander datapath. It owns the game-flow state machine, divides the 100 Hz clock into physics ticks, and produces the one-cycle `wen` strobe that commits ALU results into `ll_memory`. It also decodes synchronized keypad events into thrust setpoints and display selection, and it detects touchdown and crash from the current lander state. It sits between `keysync` and the `ll_memory`/`ll_alu` loop, and drives the seven-segment display mux.

## Interface
Parameters:
- `TICK_DIV`, default 25: clk cycles per physics tick (4 Hz at 100 Hz). Legal range 2..255.
- `THRUST_INIT`, default 16'h0005: reset thrust setpoint in BCD. Must equal `ll_memory` THRUST.
- `CRASH_VEL`, default 16'h9970: ten's-complement BCD of −30 ft/s.

Ports:
- `clk` in 1: system clock (hz100).
- `rst` in 1: reset, asynchronous, active-high.
- `keyclk` in 1: key strobe from `keysync`, level, clk-domain.
- `keyout` in 5: key code from `keysync`. Codes 0–9 are digits, 16=W, 17=X, 18=Y, 19=Z.
- `alt`, `vel`, `fuel`, `thrust` in 16 each: current BCD quantities from `ll_memory`.
- `wen` out 1: memory write strobe.
- `thrust_n` out 16: thrust setpoint to `ll_memory`.
- `disp_sel` out 2: display selector. 0=alt, 1=vel, 2=fuel, 3=thrust.
- `disp_val` out 16: selected quantity.
- `flying`, `land`, `crash` out 1: status flags.

## Operation
- Key event: `key_evt = keyclk & ~keyclk_q`, where `keyclk_q` is registered on clk. `keyout` is sampled in the same cycle.
- Key decode:
  - Codes 0–9 set `thrust_n <= {12'h000, code}` in IDLE or FLY.
  - Codes 16–19 set `disp_sel` as follows: Z→0, Y→1, X→2, W→3. This applies in every state.
  - Codes 10–15 are ignored, except as noted under Configuration.
- FSM states: IDLE, FLY, LANDED, CRASHED, and PAUSE when configured in.
  - IDLE → FLY on a digit key event. The digit is also latched as thrust.
  - FLY: tick counter `cnt` runs 0..TICK_DIV−1 and wraps. `tick = (cnt == TICK_DIV−1)`.
  - `wen = (state == FLY) & tick`. It is combinational from registered state and is exactly one cycle wide.
  - On tick, compute `sum = alt + vel` in BCD using `bcdaddsub4` with op=0. Touchdown is `sum == 0 || sum >= 16'h5000`.
    - Touchdown with `vel >= 16'h5000 && vel < CRASH_VEL` → CRASHED.
    - Any other touchdown → LANDED.
    - No touchdown → stay in FLY.
  - The touchdown tick still asserts `wen`, so memory captures the ALU-clamped alt=0 and vel=0.
  - LANDED and CRASHED are terminal. `wen` stays 0 and digit keys are ignored. Only `rst` exits.
- Status flags are `flying = (state == FLY)`, `land = (state == LANDED)`, `crash = (state == CRASHED)`.
- `disp_val` is a combinational mux of alt/vel/fuel/thrust by `disp_sel`.
- BCD sign rule: a value ≥ 16'h5000 is negative (ten's complement).

## Timing
- Reset values: state=IDLE, `cnt`=0, `keyclk_q`=0, `thrust_n`=THRUST_INIT, `disp_sel`=0, `wen`=0, `flying`=`land`=`crash`=0.
- Key-to-register latency is 1 clk. The new `thrust_n` and `disp_sel` are visible the cycle after `key_evt`.
- Entering FLY clears `cnt` to 0. The first `wen` falls on the TICK_DIV-th cycle in FLY, and subsequent ones every TICK_DIV cycles.
- Digit key and tick in the same cycle: `wen` fires, and memory captures the old `thrust_n`. The new thrust applies from the next tick.
- Status flags change one clk after the touchdown tick edge.
- A held key generates exactly one event. Release and re-press are needed for another.
- `rst` mid-flight: all registers return to reset values immediately, and `wen` drops asynchronously.

## Configuration
- `LL_PAUSE_EN` defined:
  - Key code 10 in FLY → PAUSE. In PAUSE, `cnt` is frozen, `wen`=0, and `flying`=0.
  - Key code 10 in PAUSE → FLY with `cnt` preserved.
  - Pause key and tick in the same cycle: pause wins and `wen` is 0.
  - Digit keys in PAUSE update `thrust_n`.
- `LL_PAUSE_EN` undefined: the PAUSE state is absent and code 10 is ignored.

## Structure
- Package `ll_pkg` holds:
  - the state enum `ll_state_t`;
  - key-code constants `KEY_W`..`KEY_Z` and `KEY_PAUSE`=10;
  - `BCD_NEG_TH`=16'h5000.
- Instantiates the existing `bcdaddsub4` for the touchdown sum. No new sub-module.

## Test plan
Bench uses TICK_DIV=4.
- Reset: `rst` pulse → `thrust_n`=0005, `disp_sel`=0, `wen`=0, state IDLE. No `wen` appears for 20 cycles.
- Start: digit 7 key event → `thrust_n`=0007 next cycle. `wen` pulses on cycles 4, 8, 12 after FLY entry, each exactly one cycle wide.
- Display: Y key → `disp_sel`=1 and `disp_val`=`vel`. W key → `disp_sel`=3 and `disp_val`=`thrust`. Also works in LANDED.
- Soft landing: alt=0010, vel=9980 (−20) at tick → `wen`=1, then `land`=1, `crash`=0. No further `wen`.
- Crash: alt=0040, vel=9950 (−50) at tick → `crash`=1 and `land`=0. Digit key afterward leaves `thrust_n` unchanged.
- Pause (`LL_PAUSE_EN`): code 10 at `cnt`=2 → no `wen` for 30 cycles. Code 10 again → next `wen` 2 cycles later.
